// File: rtl/aes_round_controller.sv
// Sequences one AES-128 block through an external round datapath: initial AddRoundKey
// locally, then NUM_ROUNDS datapath issues with key fetch and fixed-latency result capture.
module aes_round_controller #(
    parameter int BLOCK_LENGTH = 128,
    parameter int NUM_ROUNDS   = 10,
    parameter int ROUND_LAT    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BLOCK_LENGTH-1:0] in_block,
    output logic                    key_req,
    input  logic                    key_valid,
    input  logic [BLOCK_LENGTH-1:0] key_i,
    output logic [3:0]              round_idx,
    output logic                    dp_start,
    output logic                    dp_final,
    output logic [BLOCK_LENGTH-1:0] dp_state,
    output logic [BLOCK_LENGTH-1:0] dp_key,
    input  logic [BLOCK_LENGTH-1:0] dp_result,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BLOCK_LENGTH-1:0] out_block,
    output logic                    busy
);

    localparam int          LAT_W    = $clog2(ROUND_LAT + 1);
    localparam logic [3:0]  LAST     = 4'(NUM_ROUNDS);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ROUND_LAT);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

    typedef enum logic [2:0] {IDLE, KEY0, ISSUE, WAIT, DONE} state_t;

    state_t                  state, state_nxt;
    logic [BLOCK_LENGTH-1:0] state_reg, state_reg_nxt;
    logic [3:0]              round_nxt;
    logic                    final_q, final_nxt;
    logic [LAT_W-1:0]        lat_cnt, lat_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            state_reg <= '0;
            round_idx <= '0;
            final_q   <= 1'b0;
            lat_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            state_reg <= state_reg_nxt;
            round_idx <= round_nxt;
            final_q   <= final_nxt;
            lat_cnt   <= lat_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        state_reg_nxt = state_reg;
        round_nxt     = round_idx;
        final_nxt     = final_q;
        lat_nxt       = lat_cnt;
        in_ready      = 1'b0;
        key_req       = 1'b0;
        dp_start      = 1'b0;
        out_valid     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_reg_nxt = in_block;
                    round_nxt     = '0;
                    final_nxt     = 1'b0;
                    state_nxt     = KEY0;
                end
            end
            KEY0: begin
                key_req = 1'b1;
                if (key_valid) begin
                    state_reg_nxt = state_reg ^ key_i;
                    round_nxt     = 4'd1;
                    final_nxt     = (LAST == 4'd1);
                    state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                key_req = 1'b1;
                if (key_valid) begin
                    dp_start  = 1'b1;
                    lat_nxt   = LAT_LOAD;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                lat_nxt = lat_cnt - LAT_ONE;
                // dp_result is only meaningful in the last counted cycle
                if (lat_cnt == LAT_ONE) begin
                    state_reg_nxt = dp_result;
                    if (round_idx == LAST) begin
                        state_nxt = DONE;
                    end else begin
                        round_nxt = round_idx + 4'd1;
                        final_nxt = ((round_idx + 4'd1) == LAST);
                        state_nxt = ISSUE;
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    round_nxt = '0;
                    final_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign dp_final  = final_q;
    assign dp_state  = state_reg;
    assign dp_key    = key_i;
    assign out_block = state_reg;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_aes_round_controller.sv
// Bench for aes_round_controller: two builds (ROUND_LAT 2 and 1) driven by a behavioural
// AES key schedule and round datapath, scored against a reference AES-128 encryption.
module tb_aes_round_controller;

    localparam int NR = 10;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    logic         rst[2];
    logic         in_valid[2];
    logic [127:0] in_block[2];
    logic         out_ready[2];
    logic [127:0] key[2];
    int           stall_round[2];
    int           stall_len[2];
    logic         rnd_kv[2];

    logic         in_ready[2], key_req[2], dp_start[2], dp_final[2], out_valid[2], busy[2];
    logic [3:0]   round_idx[2];
    logic [127:0] dp_state[2], dp_key[2], out_block[2];

    logic [7:0] sbox_t [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural AES-128 ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox_t[s[127-8*i -: 8]];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r+4*c] = b[r+4*((c+r)%4)];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ k;
    endfunction

    function automatic logic [127:0] ref_enc(input logic [127:0] p, input logic [127:0] k);
        logic [127:0] s = p ^ round_key(k, 0);
        for (int r = 1; r <= NR; r++) s = aes_round(s, round_key(k, r), r == NR);
        return s;
    endfunction

    // ---------------- per-build environment ----------------
    for (genvar g = 0; g < 2; g++) begin : g_env
        localparam int LAT = (g == 0) ? 2 : 1;
        logic         key_valid = 1'b0;
        logic [127:0] key_i = '0;
        logic [127:0] dp_result, res, junk;
        int           cnt, used, t_acc, stalls, starts, exp_acc;
        logic         hold, seen;
        logic [127:0] held;
        logic [127:0] exp_q[$];

        aes_round_controller #(.BLOCK_LENGTH(128), .NUM_ROUNDS(NR), .ROUND_LAT(LAT)) dut (
            .clk(clk), .rst(rst[g]), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
            .in_block(in_block[g]), .key_req(key_req[g]), .key_valid(key_valid), .key_i(key_i),
            .round_idx(round_idx[g]), .dp_start(dp_start[g]), .dp_final(dp_final[g]),
            .dp_state(dp_state[g]), .dp_key(dp_key[g]), .dp_result(dp_result),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_block(out_block[g]),
            .busy(busy[g])
        );

        // key schedule responder; drives just after the edge so everything is stable at negedge
        always @(posedge clk) begin
            #1;
            if (in_ready[g]) used = 0;
            if (key_req[g] && int'(round_idx[g]) == stall_round[g] && used < stall_len[g]) begin
                key_valid = 1'b0;
                used++;
            end else begin
                key_valid = rnd_kv[g] ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            key_i = key_req[g] ? round_key(key[g], int'(round_idx[g])) : {4{$urandom}};
        end

        // round datapath: result presented only in the capture cycle, noise otherwise
        always @(posedge clk or posedge rst[g]) begin
            if (rst[g]) begin
                cnt <= 0;
            end else begin
                junk <= {4{$urandom}};
                if (dp_start[g]) begin
                    cnt <= LAT;
                    res <= aes_round(dp_state[g], dp_key[g], dp_final[g]);
                end else if (cnt > 0) begin
                    cnt <= cnt - 1;
                end
            end
        end
        assign dp_result = (cnt == 1) ? res : junk;

        always @(negedge clk or posedge rst[g]) begin
            if (rst[g]) begin
                exp_q.delete();
                hold = 1'b0;
                seen = 1'b0;
                exp_acc = -1;
            end else begin
                if (exp_acc == cyc) chk("acc_after_hs", 128'(in_ready[g]), 128'(1));
                if (hold) begin
                    chk("hold_valid", 128'(out_valid[g]), 128'(1));
                    chk("hold_block", out_block[g], held);
                    chk("hold_in_ready", 128'(in_ready[g]), 128'(0));
                end
                hold = out_valid[g] && !out_ready[g];
                held = out_block[g];
                if (in_valid[g] && in_ready[g]) begin
                    exp_q.push_back(ref_enc(in_block[g], key[g]));
                    t_acc = cyc; stalls = 0; starts = 0; seen = 1'b0;
                end
                if (key_req[g] && !key_valid) stalls++;
                if (dp_start[g]) begin
                    starts++;
                    chk("start_needs_key", 128'(key_valid && key_req[g]), 128'(1));
                    chk("dp_final", 128'(dp_final[g]), 128'(round_idx[g] == 4'(NR)));
                    chk("dp_key", dp_key[g], round_key(key[g], int'(round_idx[g])));
                end
                if (out_valid[g] && !seen) begin
                    seen = 1'b1;
                    chk("latency", 128'(cyc - t_acc), 128'(2 + NR * (1 + LAT) + stalls));
                    chk("start_count", 128'(starts), 128'(NR));
                    chk("final_at_done", 128'(dp_final[g]), 128'(1));
                    chk("q_len", 128'(exp_q.size()), 128'(1));
                    if (exp_q.size() != 0) chk("ciphertext", out_block[g], exp_q[0]);
                end
                if (out_valid[g] && out_ready[g]) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    seen = 1'b0;
                    exp_acc = in_valid[g] ? cyc + 1 : -1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int g, input logic [127:0] blk, input bit keep, output int t);
        int n = 0;
        @(negedge clk);
        in_valid[g] = 1'b1;
        in_block[g] = blk;
        while (!in_ready[g] && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("send_timeout", 128'(in_ready[g]), 128'(1));
        t = cyc;
        @(negedge clk);
        if (!keep) in_valid[g] = 1'b0;
    endtask

    task automatic wait_out(input int g, output int t);
        int n = 0;
        while (!out_valid[g] && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("out_timeout", 128'(out_valid[g]), 128'(1));
        t = cyc;
    endtask

    task automatic reset_chk(input int g);
        chk("rst_in_ready", 128'(in_ready[g]), 128'(1));
        chk("rst_out_valid", 128'(out_valid[g]), 128'(0));
        chk("rst_busy", 128'(busy[g]), 128'(0));
        chk("rst_key_req", 128'(key_req[g]), 128'(0));
        chk("rst_dp_start", 128'(dp_start[g]), 128'(0));
        chk("rst_dp_final", 128'(dp_final[g]), 128'(0));
        chk("rst_round_idx", 128'(round_idx[g]), 128'(0));
        chk("rst_state", dp_state[g], 128'(0));
    endtask

    initial begin
        int ta, to, n;
        logic [127:0] b1, b2;
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++) if (gm(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            sbox_t[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                      ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
        for (int g = 0; g < 2; g++) begin
            rst[g] = 1'b1; in_valid[g] = 1'b0; in_block[g] = '0; out_ready[g] = 1'b1;
            key[g] = KEY; stall_round[g] = 99; stall_len[g] = 0; rnd_kv[g] = 1'b0;
        end
        repeat (3) @(negedge clk);
        reset_chk(0);
        reset_chk(1);
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // FIPS-197 C.1, nominal latency
        send(0, PT, 0, ta);
        wait_out(0, to);
        chk("t1_latency", 128'(to - ta), 128'(32));
        chk("t1_ct", out_block[0], CT);
        @(negedge clk);
        chk("t1_idle", 128'(in_ready[0]), 128'(1));

        // three-cycle key stall in round 5
        stall_round[0] = 5; stall_len[0] = 3;
        send(0, PT, 0, ta);
        wait_out(0, to);
        chk("t2_latency", 128'(to - ta), 128'(35));
        chk("t2_ct", out_block[0], CT);
        stall_len[0] = 0;
        @(negedge clk);

        // downstream back-pressure for five cycles
        out_ready[0] = 1'b0;
        send(0, PT, 0, ta);
        wait_out(0, to);
        for (int i = 0; i < 5; i++) begin
            chk("t3_valid", 128'(out_valid[0]), 128'(1));
            chk("t3_block", out_block[0], CT);
            chk("t3_in_ready", 128'(in_ready[0]), 128'(0));
            @(negedge clk);
        end
        out_ready[0] = 1'b1;
        chk("t3_valid6", 128'(out_valid[0]), 128'(1));
        @(negedge clk);
        chk("t3_idle", 128'(in_ready[0]), 128'(1));
        chk("t3_busy", 128'(busy[0]), 128'(0));

        // in_valid held across a whole run with a second block waiting
        key[0] = {4{$urandom}};
        b1 = {4{$urandom}};
        b2 = {4{$urandom}};
        send(0, b1, 1, ta);
        in_block[0] = b2;
        wait_out(0, to);
        chk("t4_ct1", out_block[0], ref_enc(b1, key[0]));
        @(negedge clk);
        chk("t4_second_acc", 128'(in_ready[0] && in_valid[0]), 128'(1));
        @(negedge clk);
        in_valid[0] = 1'b0;
        wait_out(0, to);
        chk("t4_ct2", out_block[0], ref_enc(b2, key[0]));
        @(negedge clk);

        // random keys, blocks, key stalls and output back-pressure
        rnd_kv[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            key[0] = {4{$urandom}};
            b1 = {4{$urandom}};
            out_ready[0] = 1'b0;
            send(0, b1, 0, ta);
            wait_out(0, to);
            chk("rnd_ct", out_block[0], ref_enc(b1, key[0]));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            out_ready[0] = 1'b1;
            @(negedge clk);
        end
        rnd_kv[0] = 1'b0;

        // asynchronous reset in the middle of round 4
        key[0] = KEY;
        send(0, PT, 0, ta);
        n = 0;
        while (!(round_idx[0] == 4'd4 && busy[0] && !key_req[0]) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reach_r4", 128'(round_idx[0]), 128'(4));
        #1 rst[0] = 1'b1;
        #1 reset_chk(0);
        @(negedge clk);
        rst[0] = 1'b0;
        send(0, PT, 0, ta);
        wait_out(0, to);
        chk("t5_latency", 128'(to - ta), 128'(32));
        chk("t5_ct", out_block[0], CT);
        @(negedge clk);

        // ROUND_LAT=1 build
        send(1, PT, 0, ta);
        wait_out(1, to);
        chk("t6_latency", 128'(to - ta), 128'(22));
        chk("t6_ct", out_block[1], CT);
        @(negedge clk);
        rnd_kv[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            key[1] = {4{$urandom}};
            b1 = {4{$urandom}};
            send(1, b1, 0, ta);
            wait_out(1, to);
            chk("t6_rnd_ct", out_block[1], ref_enc(b1, key[1]));
            @(negedge clk);
        end
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
